// File: rtl/seller_pkg.sv
// Shared types for the ticket seller output path: FSM states, hopper channels
// and the order in which channels are worked off.
package seller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    WAIT_ACK,
    GAP,
    DONE
  } state_t;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    CH_TKT,
    CH_TEN,
    CH_FIVE,
    CH_ONE
  } channel_t;

  // Tickets first, then change in descending denomination.
  localparam channel_t CH_ORDER [NUM_CH] = '{CH_TKT, CH_TEN, CH_FIVE, CH_ONE};

  // Highest-priority channel whose bit is set in nz; only meaningful when nz != 0.
  function automatic channel_t first_channel(input logic [NUM_CH-1:0] nz);
    channel_t sel;
    sel = CH_ORDER[NUM_CH-1];
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (nz[CH_ORDER[i]]) sel = CH_ORDER[i];
    end
    return sel;
  endfunction

  function automatic logic [NUM_CH-1:0] channel_onehot(input channel_t ch);
    return NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter with a zero flag; shared by the pulse, gap and
// acknowledge-timeout intervals of the dispenser.
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seller_dispenser.sv
// Works off one dispense job item by item: drive pulse, wait for drop ack, gap.
// Optional acknowledge timeout with sticky fault: define SELLER_DISP_TIMEOUT_EN.
module seller_dispenser
  import seller_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] ticket_in,
  input  logic [CNT_W-1:0] ten_in,
  input  logic [CNT_W-1:0] five_in,
  input  logic [CNT_W-1:0] one_in,
  input  logic             drop_ack,
  output logic             tkt_pulse,
  output logic             ten_pulse,
  output logic             five_pulse,
  output logic             one_pulse,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int PG_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
`ifdef SELLER_DISP_TIMEOUT_EN
  localparam int TMR_MAX = (TIMEOUT_CYC > PG_MAX) ? TIMEOUT_CYC : PG_MAX;
`else
  localparam int TMR_MAX = PG_MAX;
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  if (PULSE_CYC < 1 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("seller_dispenser: PULSE_CYC, GAP_CYC and TIMEOUT_CYC must be >= 1");
  end

  state_t             state;
  channel_t           ch;
  logic [CNT_W-1:0]   count [NUM_CH];
  logic [NUM_CH-1:0]  nz;
  logic [NUM_CH-1:0]  pulse;
  channel_t           next_ch;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) nz[i] = (count[i] != '0);
  end

  assign next_ch = first_channel(nz);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      SELECT: begin
        if (nz != '0) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PULSE_CYC - 1);
        end
      end
`ifdef SELLER_DISP_TIMEOUT_EN
      PULSE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
        end
      end
`endif
      WAIT_ACK: begin
        if (drop_ack) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYC - 1);
        end
      end
      default: ;
    endcase
  end

  pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

`ifdef SELLER_DISP_TIMEOUT_EN
  logic fault_q;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // NOTE: the four job counts are only a handful of flops, so they are reset
  // along with the FSM; a large memory would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ch    <= CH_TKT;
      pulse <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) count[i] <= '0;
`ifdef SELLER_DISP_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count[CH_TKT]  <= ticket_in;
            count[CH_TEN]  <= ten_in;
            count[CH_FIVE] <= five_in;
            count[CH_ONE]  <= one_in;
            busy           <= 1'b1;
            state          <= SELECT;
`ifdef SELLER_DISP_TIMEOUT_EN
            fault_q        <= 1'b0;
`endif
          end
        end
        SELECT: begin
          if (nz == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ch    <= next_ch;
            pulse <= channel_onehot(next_ch);
            state <= PULSE;
          end
        end
        PULSE: begin
          if (tmr_zero) begin
            pulse <= '0;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (drop_ack) begin
            count[ch] <= count[ch] - CNT_W'(1);
            state     <= GAP;
          end
`ifdef SELLER_DISP_TIMEOUT_EN
          else if (tmr_zero) begin
            // Hopper jammed or empty: abandon the rest of the job.
            for (int i = 0; i < NUM_CH; i++) count[i] <= '0;
            fault_q <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end
`endif
        end
        GAP: begin
          if (tmr_zero) state <= SELECT;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tkt_pulse  = pulse[CH_TKT];
  assign ten_pulse  = pulse[CH_TEN];
  assign five_pulse = pulse[CH_FIVE];
  assign one_pulse  = pulse[CH_ONE];

endmodule

// File: tb/tb_seller_dispenser.sv
// Self-checking bench for seller_dispenser: directed and randomized jobs
// against a job-level reference model of pulse order and cycle counts.
module tb_seller_dispenser;

  localparam int CNT_W       = 4;
  localparam int PULSE_CYC   = 4;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int BOUND       = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] ticket_in = '0, ten_in = '0, five_in = '0, one_in = '0;
  logic             drop_ack;
  logic             tkt_pulse, ten_pulse, five_pulse, one_pulse;
  logic             busy, done, fault;

  logic ack_auto = 1'b1;
  logic ack_manual = 1'b0;
  logic auto_ack = 1'b0;
  assign drop_ack = ack_auto ? auto_ack : ack_manual;

  seller_dispenser #(
    .CNT_W(CNT_W), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ticket_in(ticket_in), .ten_in(ten_in), .five_in(five_in), .one_in(one_in),
    .drop_ack(drop_ack),
    .tkt_pulse(tkt_pulse), .ten_pulse(ten_pulse), .five_pulse(five_pulse), .one_pulse(one_pulse),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int got[$];
  int wq[$];
  int dmax = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {one_pulse, five_pulse, ten_pulse, tkt_pulse};
  endfunction

  // Pulse monitor: records channel order, checks width, gap and exclusivity.
  logic [3:0] prev_pv = '0;
  int width = 0;
  int low = 1000;
  always @(negedge clk) begin
    logic [3:0] pv;
    pv = pulses();
    if (!rst_n) begin
      prev_pv = '0;
      width = 0;
      low = 1000;
    end else begin
      check("pulse_onehot", int'($onehot0(pv)), 1);
      if (done === 1'b1) done_cnt++;
      if (pv != 0 && prev_pv == 0) begin
        check("pulse_gap_ge2", int'(low >= 2), 1);
        case (pv)
          4'b0001: got.push_back(0);
          4'b0010: got.push_back(1);
          4'b0100: got.push_back(2);
          default: got.push_back(3);
        endcase
        width = 1;
      end else if (pv != 0) begin
        check("pulse_stable", int'(pv), int'(prev_pv));
        width++;
      end else if (prev_pv != 0) begin
        check("pulse_width", width, PULSE_CYC);
        low = 1;
      end else if (low < 1000) begin
        low++;
      end
      prev_pv = pv;
    end
  end

  // Ack responder: after each pulse falls, waits a random delay, acks for one cycle.
  int r_state = 0;
  int r_delay = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      r_state = 0;
      auto_ack = 1'b0;
    end else begin
      case (r_state)
        0: if (pulses() != 0) r_state = 1;
        1: if (pulses() == 0) begin
          r_delay = int'($urandom_range(0, dmax));
          wq.push_back(r_delay + 1);
          if (r_delay == 0) begin
            auto_ack = 1'b1;
            r_state = 3;
          end else r_state = 2;
        end
        2: begin
          r_delay--;
          if (r_delay == 0) begin
            auto_ack = 1'b1;
            r_state = 3;
          end
        end
        default: begin
          auto_ack = 1'b0;
          r_state = 0;
        end
      endcase
    end
  end

  task automatic start_job(input int t, input int te, input int f, input int o);
    @(negedge clk);
    ticket_in = CNT_W'(t);
    ten_in    = CNT_W'(te);
    five_in   = CNT_W'(f);
    one_in    = CNT_W'(o);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // n holds the cycle index after the accepting edge (1 = SELECT cycle).
  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done), 1);
  endtask

  task automatic wait_level(input logic lvl, input string tag);
    int k;
    k = 0;
    while (((pulses() != 0) !== lvl) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'(pulses() != 0), int'(lvl));
  endtask

  // Reference model: items expand in priority order; each costs
  // SELECT + pulse + ack wait + gap, plus the final SELECT and DONE.
  task automatic run_job(input string tag, input int t, input int te, input int f,
                         input int o, input int w_each);
    int exp_q[$];
    int cnts[4];
    int n, sumw, items;
    cnts = '{t, te, f, o};
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < cnts[c]; j++) exp_q.push_back(c);
    got.delete();
    wq.delete();
    start_job(t, te, f, o);
    n = 1;
    check({tag, "_busy"}, int'(busy), 1);
    wait_done(n);
    items = exp_q.size();
    sumw = 0;
    if (w_each < 0) foreach (wq[i]) sumw += wq[i];
    else sumw = items * w_each;
    check({tag, "_cycles"}, n, 2 + items * (1 + PULSE_CYC + GAP_CYC) + sumw);
    check({tag, "_count"}, got.size(), items);
    for (int i = 0; i < items && i < got.size(); i++)
      check({tag, "_order"}, got[i], exp_q[i]);
    @(negedge clk);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_idle_done"}, int'(done), 0);
  endtask

  initial begin
    int n, d0;
    #12;
    check("rst_pulses", int'(pulses()), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero job: done two cycles after the accepting edge.
    got.delete();
    start_job(0, 0, 0, 0);
    check("zero_busy_k1", int'(busy), 1);
    check("zero_done_k1", int'(done), 0);
    @(negedge clk);
    check("zero_busy_k2", int'(busy), 1);
    check("zero_done_k2", int'(done), 1);
    @(negedge clk);
    check("zero_busy_k3", int'(busy), 0);
    check("zero_done_k3", int'(done), 0);
    check("zero_no_pulse", got.size(), 0);

    // Directed job, ack in the first WAIT_ACK cycle.
    dmax = 0;
    run_job("dir", 2, 0, 1, 3, -1);

    // Second start while busy is ignored.
    got.delete();
    wq.delete();
    start_job(1, 0, 0, 0);
    n = 1;
    while (tkt_pulse !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ign_first_rise", n, 2);
    ticket_in = CNT_W'(5);
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    wait_done(n);
    check("ign_count", got.size(), 1);
    check("ign_cycles", n, 2 + (1 + PULSE_CYC + GAP_CYC) + (wq.size() > 0 ? wq[0] : 0));
    @(negedge clk);

    // drop_ack held high for a whole job.
    ack_auto = 1'b0;
    ack_manual = 1'b1;
    run_job("held", 3, 0, 0, 0, 1);
    ack_manual = 1'b0;
    ack_auto = 1'b1;

    // Asynchronous reset in mid-pulse.
    got.delete();
    start_job(4, 0, 0, 0);
    wait_level(1'b1, "rst_mid_rise");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_pulses", int'(pulses()), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    got.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("rst_after_pulses", got.size(), 0);
    check("rst_after_busy", int'(busy), 0);
    check("rst_after_done", done_cnt - d0, 0);

    // Randomized jobs against the model.
    dmax = 3;
    for (int r = 0; r < 6; r++) begin
      run_job("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    end
    dmax = 1;
    run_job("max_ten", 0, (1 << CNT_W) - 1, 0, 0, -1);
    dmax = 0;

`ifdef SELLER_DISP_TIMEOUT_EN
    // No ack: timeout raises fault and ends the job.
    ack_auto = 1'b0;
    ack_manual = 1'b0;
    got.delete();
    start_job(0, 0, 0, 2);
    wait_level(1'b1, "to_rise");
    wait_level(1'b0, "to_fall");
    n = 0;
    while (done !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("to_done_delay", n, TIMEOUT_CYC);
    check("to_fault", int'(fault), 1);
    check("to_one_item", got.size(), 1);
    @(negedge clk);
    check("to_fault_sticky", int'(fault), 1);
    check("to_busy_low", int'(busy), 0);
    repeat (10) @(negedge clk);
    check("to_no_second", got.size(), 1);
    start_job(0, 0, 0, 0);
    check("to_fault_clear", int'(fault), 0);
    n = 1;
    wait_done(n);
    ack_auto = 1'b1;
`else
    // No ack: WAIT_ACK waits indefinitely without fault.
    ack_auto = 1'b0;
    ack_manual = 1'b0;
    got.delete();
    start_job(0, 0, 0, 1);
    wait_level(1'b1, "wait_rise");
    wait_level(1'b0, "wait_fall");
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    check("wait_no_done", done_cnt - d0, 0);
    check("wait_busy", int'(busy), 1);
    check("wait_fault", int'(fault), 0);
    ack_manual = 1'b1;
    @(negedge clk);
    ack_manual = 1'b0;
    n = 1;
    wait_done(n);
    check("wait_count", got.size(), 1);
    ack_auto = 1'b1;
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
